// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, FSM state encoding and parity helper.
// Used by the host transmitter and by the keyboard receiver.
package ps2_pkg;
  localparam int   DATA_BITS = 8;
  localparam int   BIT_CNT_W = $clog2(DATA_BITS);
  localparam logic ACK_LEVEL = 1'b0;  // device pulls data low to acknowledge

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAIT_IDLE
  } ps2_state_t;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data pads, plus a
// falling-edge strobe on the synchronized clock.
module ps2_line_sync (
  input  logic fclk,
  input  logic rst,
  input  logic clkin,
  input  logic datain,
  output logic clk_s,
  output logic data_s,
  output logic fall
);
  logic [1:0] clk_sync_reg;
  logic [1:0] data_sync_reg;
  logic       clk_prev_reg;

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], clkin};
      data_sync_reg <= {data_sync_reg[0], datain};
      clk_prev_reg  <= clk_sync_reg[1];
    end
  end

  assign clk_s  = clk_sync_reg[1];
  assign data_s = data_sync_reg[1];
  assign fall   = clk_prev_reg & ~clk_sync_reg[1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Define PS2_TX_TIMEOUT_EN to enable the REQ..WAIT_IDLE watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic                 fclk,
  input  logic                 rst,
  input  logic                 clkin,
  input  logic                 datain,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 clk_oe,
  output logic                 data_oe,
  output logic                 done,
  output logic                 err
);
  logic clk_s, data_s, fall;

  ps2_line_sync u_sync (
    .fclk   (fclk),
    .rst    (rst),
    .clkin  (clkin),
    .datain (datain),
    .clk_s  (clk_s),
    .data_s (data_s),
    .fall   (fall)
  );

  ps2_state_t           state_reg;
  logic [DATA_BITS-1:0] sr_reg;
  logic                 par_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [CNT_W-1:0]     cnt_reg;

`ifndef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] unused_timeout = CNT_W'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      sr_reg      <= '0;
      par_reg     <= 1'b0;
      bit_cnt_reg <= '0;
      cnt_reg     <= '0;
      tx_ready    <= 1'b1;
      clk_oe      <= 1'b0;
      data_oe     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          clk_oe   <= 1'b0;
          data_oe  <= 1'b0;
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            sr_reg    <= tx_data;
            par_reg   <= odd_parity(tx_data);
            cnt_reg   <= '0;
            clk_oe    <= 1'b1;
            tx_ready  <= 1'b0;
            state_reg <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_reg == CNT_W'(INHIBIT_CYCLES - 1)) begin
            clk_oe    <= 1'b0;
            data_oe   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= REQ;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        REQ: if (fall) begin
          data_oe     <= ~sr_reg[0];
          bit_cnt_reg <= '0;
          state_reg   <= DATA;
        end
        DATA: if (fall) begin
          if (bit_cnt_reg == BIT_CNT_W'(DATA_BITS - 1)) begin
            data_oe   <= ~par_reg;
            state_reg <= PARITY;
          end else begin
            // sr_reg[0] is already on the line, so the next bit is sr_reg[1]
            sr_reg      <= sr_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            data_oe     <= ~sr_reg[1];
          end
        end
        PARITY: if (fall) begin
          data_oe   <= 1'b0;
          state_reg <= STOP;
        end
        STOP: if (fall) begin
          if (data_s == ACK_LEVEL) begin
            state_reg <= WAIT_IDLE;
          end else begin
            err       <= 1'b1;
            state_reg <= IDLE;
          end
        end
        WAIT_IDLE: if (clk_s && data_s) begin
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides any protocol step taken in the same cycle
      if (state_reg inside {REQ, DATA, PARITY, STOP, WAIT_IDLE}) begin
        if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          clk_oe    <= 1'b0;
          data_oe   <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b1;
          state_reg <= IDLE;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized frames against an open-drain PS/2 device model;
// expected frame bits are derived from the byte value and its one-count.
module tb_ps2_host_tx;
  localparam int INH = 6000;
  localparam int TMO = 1000;

  logic       fclk = 1'b0;
  logic       rst  = 1'b0;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, clk_oe, data_oe, done, err;

  wire clk_line  = dev_clk & ~clk_oe;
  wire data_line = dev_data & ~data_oe;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, pulse_cyc = 0;
  int run = 0, last_run = 0;
  logic [1:0] pulse_oe = 2'b00;
  logic pulse_ready = 1'b0, after_ready = 1'b0, prev_pulse = 1'b0;
  bit scramble = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
    .fclk     (fclk),
    .rst      (rst),
    .clkin    (clk_line),
    .datain   (data_line),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .clk_oe   (clk_oe),
    .data_oe  (data_oe),
    .done     (done),
    .err      (err)
  );

  always #5 fclk = ~fclk;

  // Observation only: pulse counts, state around pulses, clk_oe run lengths
  always @(posedge fclk) begin
    cyc++;
    #1;
    if (prev_pulse) after_ready = tx_ready;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (done || err) begin
      pulse_oe    = {clk_oe, data_oe};
      pulse_ready = tx_ready;
      pulse_cyc   = cyc;
    end
    prev_pulse = done || err;
    if (clk_oe) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge fclk);
    if (scramble) tx_data = 8'($urandom);
  endtask

  function automatic logic [9:0] expected_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit ack, input bit hold,
                            input bit skip_accept, input logic [7:0] next_b, input int h);
    int n, d0, e0, fall11;
    logic [9:0] got;
    bit saw_ready;
    got = '0; saw_ready = 1'b0; fall11 = 0;
    d0 = done_cnt; e0 = err_cnt;
    if (!skip_accept) begin
      n = 0;
      while (tx_ready !== 1'b1 && n < 1000) begin tick(); n++; end
      check("ready_before_send", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      scramble = hold;
      tick();
    end
    if (!hold) tx_valid = 1'b0;
    check("clk_oe_after_accept", clk_oe, 1);
    check("ready_low_after_accept", tx_ready, 0);
    n = 0;
    while (clk_oe === 1'b1 && n < INH + 100) begin tick(); n++; end
    check("inhibit_len", last_run, INH);
    check("start_bit_drive", data_oe, 1);
    repeat (10) tick();
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == 11) fall11 = cyc;
      repeat (h) begin
        tick();
        if (k < 11 && tx_ready) saw_ready = 1'b1;
      end
      if (k <= 10) got[k-1] = data_line;
      dev_clk = 1'b1;
      if (k == 10 && ack) dev_data = 1'b0;
      if (k == 11 && hold) begin
        scramble = 1'b0;
        tx_data  = next_b;
      end
      repeat (h) begin
        tick();
        if (k < 11 && tx_ready) saw_ready = 1'b1;
      end
      if (k == 11) dev_data = 1'b1;
    end
    n = 0;
    while ((done_cnt + err_cnt) == (d0 + e0) && n < 200) begin tick(); n++; end
    tick();
    tick();
    check("frame_bits", got, expected_frame(b));
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("err_pulses", err_cnt - e0, ack ? 0 : 1);
    check("oe_at_pulse", pulse_oe, 0);
    check("ready_at_pulse", pulse_ready, 0);
    check("ready_after_pulse", after_ready, 1);
    check("no_ready_midframe", saw_ready, 0);
    if (!ack) check("err_latency", pulse_cyc - fall11, 3);
    $display("frame byte=%02h ack=%0d hold=%0d half=%0d line_bits=%03h done=%0d err=%0d",
             b, ack, hold, h, got, done_cnt - d0, err_cnt - e0);
  endtask

  initial begin
    int n;
    logic [7:0] rb;
    bit rack;
    int rh;

    repeat (3) tick();
    check("reset_ready", tx_ready, 1);
    check("reset_oe", {clk_oe, data_oe}, 0);
    check("reset_pulses", {done, err}, 0);
    rst = 1'b1;
    repeat (3) tick();

    dev_clk = 1'b0;
    repeat (5) tick();
    dev_clk = 1'b1;
    repeat (5) tick();
    check("idle_glitch_ready", tx_ready, 1);
    check("idle_glitch_oe", {clk_oe, data_oe}, 0);

    send_frame(8'hED, 1'b1, 1'b0, 1'b0, 8'h00, 25);
    send_frame(8'hF4, 1'b1, 1'b0, 1'b0, 8'h00, 20);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 20);

    // Reset while data bit 4 is on the line
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (clk_oe === 1'b1 && n < INH + 100) begin tick(); n++; end
    repeat (10) tick();
    for (int k = 1; k <= 5; k++) begin
      dev_clk = 1'b0;
      repeat (20) tick();
      dev_clk = 1'b1;
      if (k < 5) repeat (20) tick();
    end
    repeat (10) tick();
    check("mid_data_bit4_drive", data_oe, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_oe", {clk_oe, data_oe}, 0);
    check("async_rst_ready", tx_ready, 1);
    $display("reset asserted during data bit 4");
    tick();
    rst = 1'b1;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (3) tick();
    check("post_rst_ready", tx_ready, 1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 20);

    // tx_valid held high with tx_data changing: back-to-back frames
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 8'hA5, 20);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8'h00, 20);

    for (int r = 0; r < 3; r++) begin
      rb   = 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      rh   = $urandom_range(12, 30);
      send_frame(rb, rack, 1'b0, 1'b0, 8'h00, rh);
    end

`ifdef PS2_TX_TIMEOUT_EN
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (clk_oe === 1'b1 && n < INH + 100) begin tick(); n++; end
    check("timeout_inhibit_len", last_run, INH);
    n = 0;
    while (err !== 1'b1 && n < 3 * TMO) begin tick(); n++; end
    check("timeout_latency", n, TMO);
    check("timeout_oe", {clk_oe, data_oe}, 0);
    tick();
    check("timeout_ready", tx_ready, 1);
    $display("timeout frame byte=55 cycles_to_err=%0d", n);
`endif

    check("pulse_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard over the same two open-drain lines that the keyboard receiver listens on.
- Performs the clock-inhibit request, start bit, 8 data bits LSB-first, odd parity, stop bit, and device-ACK check.
- Sits beside the receiver in the keyboard front end, runs on the system clock fclk, and drives the pads only through active-high pull-low enables.

Parameters:
- INHIBIT_CYCLES, 6000: fclk cycles that clock is held low before the request (≥100 us at 50 MHz, with margin).
- TIMEOUT_CYCLES, 1000000: watchdog limit in fclk cycles from end of inhibit to ACK (≈20 ms at 50 MHz).
- CNT_W, 20: width of the shared inhibit/watchdog counter.

Ports:
- fclk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- clkin  in  1  raw PS/2 clock pad value
- datain  in  1  raw PS/2 data pad value
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high
- clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
- data_oe  out  1  1 = pull PS/2 data low, 0 = release
- done  out  1  one-cycle pulse: frame sent and ACK received
- err  out  1  one-cycle pulse: ACK missing or watchdog expired

Behaviour:
- Reset (rst=0, async): state IDLE; clk_oe=0, data_oe=0, done=0, err=0, tx_ready=1; sync flops = 1; counters = 0. Reset mid-frame releases both lines immediately.
- Line sync: 2-flop synchronizers on clkin and datain. fall = (previous synced clock = 1) and (current synced clock = 0). All protocol decisions use synced values only.
- Parity: par = ~^tx_data, computed on the latched byte.
- Accept: on tx_valid and tx_ready, latch tx_data into a shift register and go to INHIBIT. clk_oe=1 from the next cycle.
- IDLE: both lines released. tx_valid is ignored while tx_ready=0; no queuing.
- INHIBIT: clk_oe=1, data_oe=0. Count INHIBIT_CYCLES. Then data_oe=1 (start bit), clk_oe=0 in the same cycle, go to REQ. Watchdog cleared.
- REQ: data_oe=1. On fall #1, drive bit0 (data_oe = ~sr[0]) and go to DATA with bit_cnt=0.
- DATA: on each fall, if bit_cnt=7, drive ~par and go to PARITY; otherwise shift right, bit_cnt+1, drive the next bit. Data changes only in the fclk cycle after fall is detected.
- PARITY: on fall (#10), data_oe=0 (stop bit released), go to STOP.
- STOP: on fall (#11), sample synced data.
  - 0 (ACK): go to WAIT_IDLE.
  - 1: pulse err, go to IDLE.
- WAIT_IDLE: wait until synced clock and data are both 1, then pulse done and go to IDLE.
- Watchdog (REQ through WAIT_IDLE): increments every cycle. On reaching TIMEOUT_CYCLES: release both lines, pulse err, go to IDLE.
- Pulse exclusivity: done and err are never asserted together. A pulse and a new accept cannot share a cycle, because ready returns the cycle after the pulse.
- Glitch rule: a fall in INHIBIT or IDLE is ignored.

Optional Feature:
- PS2_TX_TIMEOUT_EN defined: watchdog and TIMEOUT_CYCLES are active as above.
- Undefined: no watchdog. err comes only from a missing ACK. A stalled device holds the block in its current state until rst.

Decomposition:
- ps2_pkg holds:
  - state encodings: IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAIT_IDLE
  - DATA_BITS=8 and frame constants
  - This package is shared with the keyboard receiver.
- Sub-module ps2_line_sync: 2-flop synchronizers plus falling-edge detect, outputs clk_s, data_s, fall. Reused by the receiver.

Test Plan:
- Send 0xED with a device model that clocks at 12 kHz and ACKs: clk_oe high for exactly 6000 cycles; bits on data_oe inverted = 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; err stays 0.
- Send 0xF4: parity bit 0 (data_oe=1 during PARITY); done pulses.
- Device model omits ACK (data high at fall #11) with tx_data=0x00: err pulses the cycle after fall #11; both oe=0; tx_ready=1.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES=1000, the device never clocks after the request: err pulses 1000 cycles after REQ entry; both lines released.
- Assert rst low during DATA bit 4: clk_oe=data_oe=0 asynchronously; after release, tx_ready=1 and a fresh 0xFF send completes with done.
- Hold tx_valid high across a whole frame with a changing tx_data: only the byte latched at accept is sent; a second frame starts only after done.
